// File: rtl/token_sched_pkg.sv
// Shared types and constants for the token-repeat scheduler.
// Optional feature macro used by the top: TOKEN_SCHED_OVF_MASK_EN.
package token_sched_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_REPEAT  = 2;
   localparam int DEF_MAX_RUN = 200;

   // Bits needed to hold values 0..maxval (never less than one bit)
   function automatic int cnt_w(input int maxval);
      return (maxval < 2) ? 1 : $clog2(maxval + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: masked request search starting at the owned pointer,
// one-hot grant plus encoded index; pointer advances past the grantee.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst_ni,
   input  logic [N-1:0]         req_i,
   input  logic [N-1:0]         mask_i,
   input  logic                 en_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  elig;
   logic [N-1:0]  grant;
   logic [IW-1:0] idx;
   logic          found;

   assign elig = req_i & mask_i;

   // Find the first eligible requester at or after the pointer, wrapping
   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_q) + k) % N;
         if (!found && elig[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

   // Pointer moves to the slot after the grantee only when a grant is issued
   always_comb begin
      ptr_d = ptr_q;
      if (en_i && found) begin
         ptr_d = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
      end
   end

   // Pointer register
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

   assign grant_o = en_i ? grant : '0;
   assign idx_o   = idx;

endmodule

// File: rtl/token_repeat_sched.sv
// Round-robin token-repeat scheduler: a granted '1' is emitted REPEAT times,
// a '0' once, on a single serial output. Per-requester consecutive-'1' run
// counters raise a sticky overflow flag. When TOKEN_SCHED_OVF_MASK_EN is
// defined, overflowed requesters are dropped from arbitration until reset.
module token_repeat_sched
   import token_sched_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int REPEAT  = DEF_REPEAT,
   parameter int MAX_RUN = DEF_MAX_RUN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ-1:0]         req_token,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     out_valid,
   output logic                     out_token,
   output logic [$clog2(N_REQ)-1:0] out_id,
   input  logic                     out_ready,
   output logic [N_REQ-1:0]         overflow,
   output logic                     busy
);

   localparam int IW = $clog2(N_REQ);
   localparam int BW = cnt_w(REPEAT);
   localparam int RW = cnt_w(MAX_RUN + 1);

   state_e           state_q, state_d;
   logic [BW-1:0]    beats_q, beats_d;
   logic             tok_q, tok_d;
   logic [IW-1:0]    id_q, id_d;
   logic [RW-1:0]    run_q [N_REQ];
   logic [RW-1:0]    run_d [N_REQ];
   logic [N_REQ-1:0] ovf_q, ovf_d;
   logic [N_REQ-1:0] arb_mask;
   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    gidx;
   logic             arb_en;
   logic             accept;
   logic             acc_tok;
   logic             last_beat;

`ifdef TOKEN_SCHED_OVF_MASK_EN
   assign arb_mask = ~ovf_q;
`else
   assign arb_mask = '1;
`endif

   // A new token may enter when nothing is held or the final beat leaves this cycle
   assign last_beat = (state_q == ST_EMIT) && out_ready && (beats_q == BW'(1));
   assign arb_en    = rst && ((state_q == ST_IDLE) || last_beat);
   assign accept    = |grant;
   assign acc_tok   = req_token[gidx];
   assign req_ready = grant;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk     (clk),
      .rst_ni  (rst),
      .req_i   (req_valid),
      .mask_i  (arb_mask),
      .en_i    (arb_en),
      .grant_o (grant),
      .idx_o   (gidx)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // FSM next state: leave EMIT only on the last beat without a refill
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_EMIT;
         ST_EMIT: if (last_beat && !accept) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      out_valid = (state_q == ST_EMIT);
      busy      = (state_q == ST_EMIT);
      out_token = tok_q;
      out_id    = id_q;
      overflow  = ovf_q;
   end

   // Beat holder: load on accept, count down on consumption, hold on stall
   always_comb begin
      beats_d = beats_q;
      tok_d   = tok_q;
      id_d    = id_q;
      if (accept) begin
         beats_d = acc_tok ? BW'(REPEAT) : BW'(1);
         tok_d   = acc_tok;
         id_d    = gidx;
      end else if ((state_q == ST_EMIT) && out_ready) begin
         beats_d = beats_q - 1'b1;
      end
   end

   // Run counters: '1' counts up (saturating), '0' clears; overflow on the (MAX_RUN+1)th '1'
   always_comb begin
      ovf_d = ovf_q;
      for (int i = 0; i < N_REQ; i++) begin
         run_d[i] = run_q[i];
         if (grant[i]) begin
            if (acc_tok) begin
               if (run_q[i] != RW'(MAX_RUN + 1)) run_d[i] = run_q[i] + 1'b1;
               if (run_q[i] == RW'(MAX_RUN))     ovf_d[i] = 1'b1;
            end else begin
               run_d[i] = '0;
            end
         end
      end
   end

   // Datapath and run-tracking registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beats_q <= '0;
         tok_q   <= 1'b0;
         id_q    <= '0;
         ovf_q   <= '0;
         for (int i = 0; i < N_REQ; i++) run_q[i] <= '0;
      end else begin
         beats_q <= beats_d;
         tok_q   <= tok_d;
         id_q    <= id_d;
         ovf_q   <= ovf_d;
         for (int i = 0; i < N_REQ; i++) run_q[i] <= run_d[i];
      end
   end

endmodule

// File: tb/tb_token_repeat_sched.sv
// Randomized scoreboard bench for token_repeat_sched (N_REQ=4, REPEAT=2, MAX_RUN=200).
module tb_token_repeat_sched;

   localparam int N    = 4;
   localparam int REP  = 2;
   localparam int MAXR = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req_valid = '0;
   logic [3:0] req_token = '0;
   logic [3:0] req_ready;
   logic       out_valid;
   logic       out_token;
   logic [1:0] out_id;
   logic       out_ready = 1'b0;
   logic [3:0] overflow;
   logic       busy;

   always #5 clk = ~clk;

   token_repeat_sched #(.N_REQ(N), .REPEAT(REP), .MAX_RUN(MAXR)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_token (req_token),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_token (out_token),
      .out_id    (out_id),
      .out_ready (out_ready),
      .overflow  (overflow),
      .busy      (busy)
   );

   typedef struct packed {
      logic       tok;
      logic [1:0] id;
   } beat_t;

   int    checks   = 0;
   int    failures = 0;
   beat_t exp_q[$];
   int    m_ptr;
   int    m_run[N];
   logic [3:0] m_ovf;
   bit    mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ptr = 0;
      m_ovf = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
   endtask

   // One clock of stimulus; predicts grant from the reference model and queues the beats
   task automatic cycle(input logic [3:0] v, input logic [3:0] t, input logic ord);
      logic [3:0] elig;
      logic [3:0] exp_rdy;
      bit         can;
      int         g;
      int         j;
      @(negedge clk);
      req_valid = v;
      req_token = t;
      out_ready = ord;
      #1;
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      chk("busy", {31'b0, busy}, {31'b0, exp_q.size() != 0});
      chk("overflow", {28'b0, overflow}, {28'b0, m_ovf});
      can  = (exp_q.size() == 0) || (exp_q.size() == 1 && ord);
      elig = v;
`ifdef TOKEN_SCHED_OVF_MASK_EN
      elig = elig & ~m_ovf;
`endif
      g = -1;
      if (can) begin
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && elig[j]) g = j;
         end
      end
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
      if (g >= 0) begin
         for (int b = 0; b < (t[g] ? REP : 1); b++) exp_q.push_back('{tok: t[g], id: 2'(g)});
         m_ptr = (g + 1) % N;
         if (t[g]) begin
            if (m_run[g] == MAXR) m_ovf[g] = 1'b1;
            if (m_run[g] < MAXR + 1) m_run[g]++;
         end else begin
            m_run[g] = 0;
         end
      end
   endtask

   // Monitor: compares every presented beat with the head of the expected queue
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (mon_en && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_beat: got tok=%0b id=%0d expected no beat", out_token, out_id);
            end else begin
               chk("beat_tok", {31'b0, out_token}, {31'b0, exp_q[0].tok});
               chk("beat_id", {30'b0, out_id}, {30'b0, exp_q[0].id});
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int n;
      model_reset();
      // Reset state, with requests offered to prove req_ready is forced low
      req_valid = 4'hF;
      req_token = 4'hF;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_token", {31'b0, out_token}, 32'd0);
      chk("rst_out_id", {30'b0, out_id}, 32'd0);
      chk("rst_overflow", {28'b0, overflow}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
      @(negedge clk);
      req_valid = '0;
      rst = 1'b1;
      mon_en = 1'b1;

      // Single '1' from req0 then idle
      cycle(4'b0001, 4'b0001, 1'b1);
      repeat (3) cycle(4'b0000, 4'b0000, 1'b1);

      // req0 '1' and req1 '0' continuously valid
      repeat (8) cycle(4'b0011, 4'b0001, 1'b1);
      repeat (3) cycle(4'b0000, 4'b0000, 1'b1);

      // Stall during the first beat of a '1'
      cycle(4'b0001, 4'b0001, 1'b1);
      repeat (5) cycle(4'b0000, 4'b0000, 1'b0);
      repeat (3) cycle(4'b0000, 4'b0000, 1'b1);

      // req2 long run of '1' -> overflow, then a '0' does not clear it
      repeat (420) cycle(4'b0100, 4'b0100, 1'b1);
      repeat (2) cycle(4'b0100, 4'b0000, 1'b1);
      repeat (3) cycle(4'b0000, 4'b0000, 1'b1);
      #2;
      chk("ovf_sticky", {28'b0, overflow}, 32'h4);

      // Random traffic with req2 overflowed
      repeat (600) cycle(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));

      // Reset in the middle of the last beat of a '1'
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         cycle(4'b0000, 4'b0000, 1'b1);
         n++;
      end
      cycle(4'b0010, 4'b0010, 1'b1);
      cycle(4'b0000, 4'b0000, 1'b1);
      @(negedge clk);
      #1;
      chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      mon_en = 1'b0;
      req_valid = 4'hF;
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_ready", {28'b0, req_ready}, 32'd0);
      chk("mid_rst_ovf", {28'b0, overflow}, 32'd0);
      @(negedge clk);
      req_valid = '0;
      rst = 1'b1;
      model_reset();
      mon_en = 1'b1;
      cycle(4'b1011, 4'b1011, 1'b1);
      repeat (300) cycle(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));

      // Drain
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         cycle(4'b0000, 4'b0000, 1'b1);
         n++;
      end
      cycle(4'b0000, 4'b0000, 1'b1);
      chk("drain_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
